// File: rtl/cfg_count_stat_mc.sv
// Multi-channel statistics counter bank: per-channel edge/level event counting with
// saturate-or-wrap overflow, sticky overflow flags, read-clear or sticky read, and global clear.
module cfg_count_stat_mc #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter bit SAT_EN    = 1'b1,
  localparam int AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_count_mode,
  input  logic [NUM_CH-1:0]    sample_mode,
  input  logic                 clr_all,
  input  logic [NUM_CH-1:0]    data_in,
  input  logic [NUM_CH-1:0]    data_in_vld,
  input  logic                 rd,
  input  logic [AW-1:0]        rd_addr,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_ovf,
  output logic                 rd_ack
);

  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  logic [CNT_WIDTH-1:0] nxt [NUM_CH];
  logic [NUM_CH-1:0]    ovf;
  logic [NUM_CH-1:0]    prev;
  logic [NUM_CH-1:0]    inc;
  logic [NUM_CH-1:0]    ovf_set;
  logic [NUM_CH-1:0]    rd_clr;

  logic                 rd_hit;
  logic [CNT_WIDTH-1:0] sel_data;
  logic                 sel_ovf;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    inc      = '0;
    ovf_set  = '0;
    rd_clr   = '0;
    rd_hit   = 1'b0;
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      nxt[i] = cnt[i];
      if (data_in_vld[i]) begin
        inc[i] = sample_mode[i] ? data_in[i] : (data_in[i] & ~prev[i]);
      end
      ovf_set[i] = inc[i] && (cnt[i] == {CNT_WIDTH{1'b1}});
      if (!(ovf_set[i] && SAT_EN)) begin
        nxt[i] = cnt[i] + CNT_WIDTH'(inc[i]);
      end
      // The read reports the post-increment value so a same-cycle event is never lost.
      if (rd && (rd_addr == AW'(i))) begin
        rd_hit    = 1'b1;
        sel_data  = nxt[i];
        sel_ovf   = ovf[i] | ovf_set[i];
        rd_clr[i] = ~rd_count_mode;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is small register state (not RAM), so it is cleared in a reset loop.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      ovf     <= '0;
      prev    <= '0;
      rd_data <= '0;
      rd_ovf  <= 1'b0;
      rd_ack  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (data_in_vld[i]) begin
          prev[i] <= data_in[i];
        end
        if (clr_all || rd_clr[i]) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else begin
          cnt[i] <= nxt[i];
          ovf[i] <= ovf[i] | ovf_set[i];
        end
      end
      rd_ack <= rd;
      // Out-of-range addresses still acknowledge, returning zero.
      if (rd) begin
        rd_data <= rd_hit ? sel_data : '0;
        rd_ovf  <= rd_hit & sel_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cfg_count_stat_mc.sv
// Scoreboard bench for cfg_count_stat_mc: a 32-bit 4-channel bank plus 4-bit 3-channel
// saturating and wrapping banks, each with its own read strobe and expectation queue.
module tb_cfg_count_stat_mc;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_count_mode;
  logic [3:0]  sample_mode;
  logic        clr_all;
  logic [3:0]  data_in;
  logic [3:0]  data_in_vld;
  logic [2:0]  rd_v;
  logic [1:0]  rd_addr;

  logic [31:0] rd_data_a;
  logic        rd_ovf_a, rd_ack_a;
  logic [3:0]  rd_data_s, rd_data_w;
  logic        rd_ovf_s, rd_ack_s, rd_ovf_w, rd_ack_w;

  int checks   = 0;
  int failures = 0;
  exp_t q [3][$];

  always #5 clk = ~clk;

  cfg_count_stat_mc #(.NUM_CH(4), .CNT_WIDTH(32), .SAT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .rd_count_mode(rd_count_mode), .sample_mode(sample_mode),
    .clr_all(clr_all), .data_in(data_in), .data_in_vld(data_in_vld), .rd(rd_v[0]),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ovf(rd_ovf_a), .rd_ack(rd_ack_a));

  cfg_count_stat_mc #(.NUM_CH(3), .CNT_WIDTH(4), .SAT_EN(1'b1)) u_s (
    .clk(clk), .rst(rst), .rd_count_mode(rd_count_mode), .sample_mode(sample_mode[2:0]),
    .clr_all(clr_all), .data_in(data_in[2:0]), .data_in_vld(data_in_vld[2:0]), .rd(rd_v[1]),
    .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .rd_ack(rd_ack_s));

  cfg_count_stat_mc #(.NUM_CH(3), .CNT_WIDTH(4), .SAT_EN(1'b0)) u_w (
    .clk(clk), .rst(rst), .rd_count_mode(rd_count_mode), .sample_mode(sample_mode[2:0]),
    .clr_all(clr_all), .data_in(data_in[2:0]), .data_in_vld(data_in_vld[2:0]), .rd(rd_v[2]),
    .rd_addr(rd_addr), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .rd_ack(rd_ack_w));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic ack, input logic [31:0] d, input logic o);
    exp_t e;
    if (ack) begin
      if (q[k].size() == 0) begin
        check($sformatf("unexpected_ack_%0d", k), 32'(ack), 32'd0);
      end else begin
        e = q[k].pop_front();
        check(e.name, d, e.data);
        check({e.name, "_ovf"}, 32'(o), 32'(e.ovf));
      end
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, rd_ack_a, rd_data_a, rd_ovf_a);
    mon(1, rd_ack_s, 32'(rd_data_s), rd_ovf_s);
    mon(2, rd_ack_w, 32'(rd_data_w), rd_ovf_w);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic d);
    data_in[ch]     = d;
    data_in_vld[ch] = v;
    tick();
    data_in[ch]     = 1'b0;
    data_in_vld[ch] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [1:0] addr, input logic mode,
                         input logic [31:0] ed, input logic eo, input string name);
    exp_t e;
    e.name = name;
    e.data = ed;
    e.ovf  = eo;
    q[k].push_back(e);
    rd_v[k]       = 1'b1;
    rd_addr       = addr;
    rd_count_mode = mode;
    tick();
    rd_v[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_count_mode = 1'b1; sample_mode = 4'b1101; clr_all = 1'b0;
    data_in = '0; data_in_vld = '0; rd_v = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_data_a", rd_data_a, 32'd0);
    check("rst_ack_a", 32'(rd_ack_a), 32'd0);
    check("rst_ovf_a", 32'(rd_ovf_a), 32'd0);
    check("rst_data_s", 32'(rd_data_s), 32'd0);

    // Level counting on ch0, then two back-to-back non-clearing reads.
    for (int i = 0; i < 10; i++) drive(0, 1'b1, 1'b1);
    do_read(0, 2'd0, 1'b1, 32'd10, 1'b0, "t1_lvl_rd1");
    do_read(0, 2'd0, 1'b1, 32'd10, 1'b0, "t1_lvl_rd2");

    // Edge counting on ch1: 0,1,1,0,1 gives two edges.
    drive(1, 1'b1, 1'b0); drive(1, 1'b1, 1'b1); drive(1, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b0); drive(1, 1'b1, 1'b1);
    do_read(0, 2'd1, 1'b1, 32'd2, 1'b0, "t2_edge");
    // Edges span valid samples only; unqualified toggles are ignored.
    drive(1, 1'b1, 1'b0); drive(1, 1'b0, 1'b1); drive(1, 1'b0, 1'b0); drive(1, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b0); drive(1, 1'b1, 1'b1);
    do_read(0, 2'd1, 1'b1, 32'd3, 1'b0, "t2_edge_gap");

    // Clearing read with a same-cycle increment.
    for (int i = 0; i < 5; i++) drive(2, 1'b1, 1'b1);
    data_in[2] = 1'b1; data_in_vld[2] = 1'b1;
    do_read(0, 2'd2, 1'b0, 32'd6, 1'b0, "t3_rdclr");
    data_in[2] = 1'b0; data_in_vld[2] = 1'b0;
    do_read(0, 2'd2, 1'b0, 32'd0, 1'b0, "t3_after_clr");

    // Global clear alongside a read; ch0 increment in that cycle is discarded.
    for (int i = 0; i < 7; i++) drive(3, 1'b1, 1'b1);
    clr_all = 1'b1; data_in[0] = 1'b1; data_in_vld[0] = 1'b1;
    do_read(0, 2'd3, 1'b1, 32'd7, 1'b0, "t5_clr_rd");
    clr_all = 1'b0; data_in[0] = 1'b0; data_in_vld[0] = 1'b0;
    for (int c = 0; c < 4; c++) do_read(0, 2'(c), 1'b1, 32'd0, 1'b0, $sformatf("t5_zero_ch%0d", c));

    // Output hold, then reset mid-count.
    for (int i = 0; i < 3; i++) drive(3, 1'b1, 1'b1);
    do_read(0, 2'd3, 1'b1, 32'd3, 1'b0, "t5_pre_rst");
    tick();
    check("t5_hold_data", rd_data_a, 32'd3);
    check("t5_idle_ack", 32'(rd_ack_a), 32'd0);
    rst = 1'b1; data_in[3] = 1'b1; data_in_vld[3] = 1'b1;
    tick();
    rst = 1'b0; data_in[3] = 1'b0; data_in_vld[3] = 1'b0;
    check("t5_rst_data", rd_data_a, 32'd0);
    check("t5_rst_ack", 32'(rd_ack_a), 32'd0);
    do_read(0, 2'd3, 1'b1, 32'd0, 1'b0, "t5_post_rst");

    // 4-bit banks: 17 level hits saturate at 15 or wrap to 1, overflow set in both.
    for (int i = 0; i < 17; i++) drive(0, 1'b1, 1'b1);
    do_read(1, 2'd0, 1'b1, 32'd15, 1'b1, "t4_sat");
    do_read(2, 2'd0, 1'b1, 32'd1, 1'b1, "t4_wrap");
    do_read(2, 2'd0, 1'b0, 32'd1, 1'b1, "t4_wrap_clr");
    do_read(2, 2'd0, 1'b1, 32'd0, 1'b0, "t4_wrap_after");

    // Out-of-range address on the 3-channel bank leaves counters untouched.
    do_read(1, 2'd3, 1'b0, 32'd0, 1'b0, "t6_oob");
    do_read(1, 2'd0, 1'b1, 32'd15, 1'b1, "t6_ch0_kept");
    do_read(1, 2'd2, 1'b1, 32'd0, 1'b0, "t6_ch2_kept");

    tick(); tick();
    for (int k = 0; k < 3; k++) check($sformatf("q_drained_%0d", k), 32'(q[k].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
